// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes/functs,
// datapath select codes and the registered per-instruction control bundle.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;

  localparam logic [2:0] NPC_PC4    = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_REG    = 3'b100;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [2:0] M2R_ALU  = 3'b000;
  localparam logic [2:0] M2R_LW   = 3'b001;
  localparam logic [2:0] M2R_LUI  = 3'b010;
  localparam logic [2:0] M2R_LINK = 3'b011;
  localparam logic [2:0] M2R_LB   = 3'b100;

  // Instruction class selects the state sequence; the other fields are raw control values.
  typedef enum logic [3:0] {
    CL_NOP   = 4'd0,
    CL_ALU   = 4'd1,
    CL_LUI   = 4'd2,
    CL_LOAD  = 4'd3,
    CL_STORE = 4'd4,
    CL_BEQ   = 4'd5,
    CL_BGTZ  = 4'd6,
    CL_JUMP  = 4'd7,
    CL_LINK  = 4'd8
  } class_e;

  typedef struct packed {
    class_e     cls;
    logic [2:0] alu;
    logic       alu_src;
    logic [1:0] ext;
    logic [2:0] npc;
    logic [1:0] reg_dst;
    logic [2:0] mem2reg;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/mc_decoder.sv
// Combinational opcode/funct decoder producing the control bundle and a legal flag.
module mc_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_o,
  output logic       legal_o
);

  always_comb begin
    ctrl_o  = CTRL_NOP;
    legal_o = 1'b1;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.reg_dst = RD_RD;
        case (funct_i)
          FN_ADD:  begin ctrl_o.cls = CL_ALU; ctrl_o.alu = ALU_ADD; end
          FN_SUB:  begin ctrl_o.cls = CL_ALU; ctrl_o.alu = ALU_SUB; end
          FN_XOR:  begin ctrl_o.cls = CL_ALU; ctrl_o.alu = ALU_XOR; end
          // funct 0 with rd=0 is the canonical nop; it simply writes $0.
          FN_SLL:  begin ctrl_o.cls = CL_ALU; ctrl_o.alu = ALU_SLL; end
          FN_JR:   begin ctrl_o.cls = CL_JUMP; ctrl_o.npc = NPC_REG; end
          FN_JALR: begin
            ctrl_o.cls     = CL_LINK;
            ctrl_o.npc     = NPC_REG;
            ctrl_o.mem2reg = M2R_LINK;
          end
          default: begin ctrl_o = CTRL_NOP; legal_o = 1'b0; end
        endcase
      end
      OP_ORI: begin
        ctrl_o.cls = CL_ALU; ctrl_o.alu = ALU_OR;
        ctrl_o.alu_src = 1'b1; ctrl_o.ext = EXT_ZERO;
      end
      OP_ADDI: begin
        ctrl_o.cls = CL_ALU; ctrl_o.alu = ALU_ADD;
        ctrl_o.alu_src = 1'b1; ctrl_o.ext = EXT_SIGN;
      end
      OP_LW, OP_LB: begin
        ctrl_o.cls = CL_LOAD; ctrl_o.alu = ALU_ADD;
        ctrl_o.alu_src = 1'b1; ctrl_o.ext = EXT_SIGN;
        ctrl_o.mem2reg = (opcode_i == OP_LW) ? M2R_LW : M2R_LB;
      end
      OP_SW: begin
        ctrl_o.cls = CL_STORE; ctrl_o.alu = ALU_ADD;
        ctrl_o.alu_src = 1'b1; ctrl_o.ext = EXT_SIGN;
      end
      OP_BEQ: begin
        ctrl_o.cls = CL_BEQ; ctrl_o.alu = ALU_SUB;
        ctrl_o.ext = EXT_SIGN; ctrl_o.npc = NPC_BRANCH;
      end
      OP_BGTZ: begin
        ctrl_o.cls = CL_BGTZ; ctrl_o.ext = EXT_SIGN; ctrl_o.npc = NPC_BRANCH;
      end
      OP_LUI: begin
        ctrl_o.cls = CL_LUI; ctrl_o.alu_src = 1'b1;
        ctrl_o.ext = EXT_LUI; ctrl_o.mem2reg = M2R_LUI;
      end
      OP_J:   begin ctrl_o.cls = CL_JUMP; ctrl_o.npc = NPC_JUMP; end
      OP_JAL: begin
        ctrl_o.cls = CL_LINK; ctrl_o.npc = NPC_JUMP;
        ctrl_o.reg_dst = RD_RA; ctrl_o.mem2reg = M2R_LINK;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with an
// instruction class register captured in DECODE and an optional memory handshake.
module multicycle_controller
  import multicycle_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W    = 3,
  parameter int MEM2REG_W     = 3,
  parameter int NPC_W         = 3,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  gtz,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic [NPC_W-1:0]      npc_control,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  alu_src,
  output logic [1:0]            ext_control,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic [1:0]            reg_dst,
  output logic [MEM2REG_W-1:0]  mem2reg,
  output logic                  instr_done,
  output logic                  illegal,
  output logic [2:0]            state
);

  state_e state_q, state_d;
  ctrl_t  cls_q, cls_d;
  ctrl_t  dec_ctrl;
  logic   dec_legal;
  logic   mem_done;
  logic [2:0] npc_c, alu_c, m2r_c;

  mc_decoder u_decoder (
    .opcode_i (opcode),
    .funct_i  (funct),
    .ctrl_o   (dec_ctrl),
    .legal_o  (dec_legal)
  );

  assign mem_done = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cls_q   <= CTRL_NOP;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    npc_c       = NPC_PC4;
    alu_c       = ALU_ADD;
    alu_src     = 1'b0;
    ext_control = EXT_ZERO;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = RD_RT;
    m2r_c       = M2R_ALU;
    instr_done  = 1'b0;
    illegal     = 1'b0;

    // ALU operand selects stay valid through MEM/WB so the address/result are stable.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      alu_c       = cls_q.alu;
      alu_src     = cls_q.alu_src;
      ext_control = cls_q.ext;
    end

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        if (dec_legal) begin
          cls_d   = dec_ctrl;
          state_d = S_EXEC;
        end else begin
          cls_d      = CTRL_NOP;
          illegal    = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXEC: begin
        case (cls_q.cls)
          CL_BEQ, CL_BGTZ, CL_JUMP: begin
            npc_c      = cls_q.npc;
            pc_write   = (cls_q.cls == CL_BEQ)  ? zero :
                         (cls_q.cls == CL_BGTZ) ? gtz  : 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          CL_LINK: begin
            npc_c    = cls_q.npc;
            pc_write = 1'b1;
            state_d  = S_WB;
          end
          CL_LOAD, CL_STORE: state_d = S_MEM;
          default:           state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_read  = (cls_q.cls == CL_LOAD);
        mem_write = (cls_q.cls == CL_STORE);
        if (mem_done) begin
          if (cls_q.cls == CL_STORE) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = cls_q.reg_dst;
        m2r_c      = cls_q.mem2reg;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign npc_control = NPC_W'(npc_c);
  assign alu_control = ALU_CTRL_W'(alu_c);
  assign mem2reg     = MEM2REG_W'(m2r_c);
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench: each instruction queues its expected per-cycle
// control snapshots, which are popped and compared on the falling clock edge.
module tb_multicycle_controller;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic       irw;
    logic [2:0] npc;
    logic [2:0] alu;
    logic       asrc;
    logic [1:0] ext;
    logic       mr;
    logic       mw;
    logic       rw;
    logic [1:0] rdst;
    logic [2:0] m2r;
    logic       done;
    logic       ill;
  } snap_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, gtz, mem_ready;
  logic       pc_write, ir_write, alu_src, mem_read, mem_write, reg_write;
  logic       instr_done, illegal;
  logic [2:0] npc_control, alu_control, mem2reg, state;
  logic [1:0] ext_control, reg_dst;

  snap_t obs;
  snap_t exp_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .gtz         (gtz),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .npc_control (npc_control),
    .alu_control (alu_control),
    .alu_src     (alu_src),
    .ext_control (ext_control),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem2reg     (mem2reg),
    .instr_done  (instr_done),
    .illegal     (illegal),
    .state       (state)
  );

  assign obs = {state, pc_write, ir_write, npc_control, alu_control, alu_src, ext_control,
                mem_read, mem_write, reg_write, reg_dst, mem2reg, instr_done, illegal};

  function automatic snap_t mk(input logic [2:0] st);
    snap_t s;
    s = '0;
    s.st = st;
    return s;
  endfunction

  function automatic snap_t ex(input logic [2:0] st, input logic [2:0] alu,
                               input logic asrc, input logic [1:0] ext);
    snap_t s;
    s = mk(st);
    s.alu = alu; s.asrc = asrc; s.ext = ext;
    return s;
  endfunction

  function automatic snap_t wb(input logic [2:0] alu, input logic asrc, input logic [1:0] ext,
                               input logic [1:0] rdst, input logic [2:0] m2r);
    snap_t s;
    s = ex(3'd5, alu, asrc, ext);
    s.rw = 1'b1; s.rdst = rdst; s.m2r = m2r; s.done = 1'b1;
    return s;
  endfunction

  task automatic push_fd();
    snap_t s;
    s = mk(3'd1);
    s.pcw = 1'b1; s.irw = 1'b1;
    exp_q.push_back(s);
    exp_q.push_back(mk(3'd2));
  endtask

  task automatic check(input string tag);
    snap_t e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  // Called just after the edge that enters FETCH; consumes every queued snapshot.
  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic g, input int w);
    int n;
    n = exp_q.size();
    opcode = op; funct = fn; zero = z; gtz = g;
    $display("txn %s op=%b funct=%b zero=%0d gtz=%0d wait=%0d cycles=%0d", tag, op, fn, z, g, w, n);
    for (int i = 0; i < n; i++) begin
      mem_ready = (i >= 3 + w);
      if (i >= 2) begin
        opcode = 6'h3f;
        funct  = 6'h3f;
      end
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    snap_t s;
    reset = 1'b0; opcode = '0; funct = '0; zero = 1'b0; gtz = 1'b0; mem_ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(3'd0));
      @(negedge clk);
      check($sformatf("reset[%0d]", i));
    end
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.push_back(mk(3'd0));
    @(negedge clk);
    check("release_idle");
    @(posedge clk); #1;

    push_fd();
    exp_q.push_back(ex(3'd3, 3'b000, 1'b0, 2'b00));
    exp_q.push_back(wb(3'b000, 1'b0, 2'b00, 2'b01, 3'b000));
    run("add", 6'b000000, 6'b100000, 1'b0, 1'b0, 0);

    push_fd();
    exp_q.push_back(ex(3'd3, 3'b000, 1'b1, 2'b01));
    s = ex(3'd4, 3'b000, 1'b1, 2'b01); s.mr = 1'b1;
    repeat (3) exp_q.push_back(s);
    exp_q.push_back(wb(3'b000, 1'b1, 2'b01, 2'b00, 3'b001));
    run("lw_wait2", 6'b100011, 6'b010101, 1'b0, 1'b0, 2);

    push_fd();
    s = ex(3'd3, 3'b001, 1'b0, 2'b01); s.npc = 3'b001; s.done = 1'b1;
    exp_q.push_back(s);
    run("beq_z0", 6'b000100, 6'b000000, 1'b0, 1'b1, 0);

    push_fd();
    s.pcw = 1'b1;
    exp_q.push_back(s);
    run("beq_z1", 6'b000100, 6'b000000, 1'b1, 1'b0, 0);

    push_fd();
    s = ex(3'd3, 3'b000, 1'b0, 2'b00); s.pcw = 1'b1; s.npc = 3'b010;
    exp_q.push_back(s);
    exp_q.push_back(wb(3'b000, 1'b0, 2'b00, 2'b10, 3'b011));
    run("jal", 6'b000011, 6'b000000, 1'b0, 1'b0, 0);

    s = mk(3'd1); s.pcw = 1'b1; s.irw = 1'b1;
    exp_q.push_back(s);
    s = mk(3'd2); s.ill = 1'b1; s.done = 1'b1;
    exp_q.push_back(s);
    run("illegal_op", 6'b111111, 6'b000000, 1'b1, 1'b1, 0);

    s = mk(3'd1); s.pcw = 1'b1; s.irw = 1'b1;
    exp_q.push_back(s);
    s = mk(3'd2); s.ill = 1'b1; s.done = 1'b1;
    exp_q.push_back(s);
    run("illegal_funct", 6'b000000, 6'b111111, 1'b0, 1'b0, 0);

    push_fd();
    exp_q.push_back(ex(3'd3, 3'b011, 1'b1, 2'b00));
    exp_q.push_back(wb(3'b011, 1'b1, 2'b00, 2'b00, 3'b000));
    run("ori", 6'b001101, 6'b100000, 1'b0, 1'b0, 0);

    push_fd();
    s = ex(3'd3, 3'b000, 1'b0, 2'b00); s.pcw = 1'b1; s.npc = 3'b100; s.done = 1'b1;
    exp_q.push_back(s);
    run("jr", 6'b000000, 6'b001000, 1'b0, 1'b0, 0);

    push_fd();
    exp_q.push_back(ex(3'd3, 3'b000, 1'b1, 2'b01));
    s = ex(3'd4, 3'b000, 1'b1, 2'b01); s.mw = 1'b1; s.done = 1'b1;
    exp_q.push_back(s);
    run("sw_nowait", 6'b101011, 6'b000000, 1'b0, 1'b0, 0);

    push_fd();
    s = ex(3'd3, 3'b000, 1'b0, 2'b01); s.pcw = 1'b1; s.npc = 3'b001; s.done = 1'b1;
    exp_q.push_back(s);
    run("bgtz_taken", 6'b000111, 6'b000000, 1'b0, 1'b1, 0);

    push_fd();
    exp_q.push_back(ex(3'd3, 3'b000, 1'b1, 2'b10));
    exp_q.push_back(wb(3'b000, 1'b1, 2'b10, 2'b00, 3'b010));
    run("lui", 6'b001111, 6'b000000, 1'b0, 1'b0, 0);

    push_fd();
    exp_q.push_back(ex(3'd3, 3'b100, 1'b0, 2'b00));
    exp_q.push_back(wb(3'b100, 1'b0, 2'b00, 2'b01, 3'b000));
    run("sll_nop", 6'b000000, 6'b000000, 1'b0, 1'b0, 0);

    // sw stalled in MEM, then reset dropped between clock edges
    push_fd();
    exp_q.push_back(ex(3'd3, 3'b000, 1'b1, 2'b01));
    s = ex(3'd4, 3'b000, 1'b1, 2'b01); s.mw = 1'b1;
    exp_q.push_back(s);
    exp_q.push_back(s);
    run("sw_stall", 6'b101011, 6'b000000, 1'b0, 1'b0, 100);
    #1;
    exp_q.push_back(s);
    check("sw_stall_held");
    reset = 1'b0;
    #1;
    exp_q.push_back(mk(3'd0));
    check("async_reset_abort");
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.push_back(mk(3'd0));
    @(negedge clk);
    check("rerelease_idle");
    @(posedge clk); #1;

    push_fd();
    exp_q.push_back(ex(3'd3, 3'b001, 1'b0, 2'b00));
    exp_q.push_back(wb(3'b001, 1'b0, 2'b00, 2'b01, 3'b000));
    run("sub_after_reset", 6'b000000, 6'b100010, 1'b0, 1'b0, 0);

    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
